// File: rtl/avg_diff_scheduler_if.sv
// rtl/avg_diff_scheduler_if.sv - channel request/sample and result bundle for avg_diff_scheduler
interface avg_diff_scheduler_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] ser_in;
    logic [NCH-1:0]    grant;
    logic              sample_en;
    logic              res_valid;
    logic [CHW-1:0]    res_ch;
    logic [DW-1:0]     res_avg;
    logic [DW-1:0]     res_diff;
    logic              done;

    // Sample front ends and the result consumer sit on the master side.
    modport master (
        output req, ser_in,
        input  grant, sample_en, res_valid, res_ch, res_avg, res_diff, done
    );

    modport slave (
        input  req, ser_in,
        output grant, sample_en, res_valid, res_ch, res_avg, res_diff, done
    );
endinterface

// File: rtl/avg_diff_scheduler.sv
// rtl/avg_diff_scheduler.sv - round-robin burst average / abs-difference scheduler (optional AVG_ROUND_EN)
module avg_diff_scheduler #(
    parameter int NCH     = 4,
    parameter int SAMPLES = 4,
    parameter int DW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    avg_diff_scheduler_if.slave  bus
);
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SHIFT = $clog2(SAMPLES);
    localparam int CNTW  = (SHIFT > 0) ? SHIFT : 1;
    localparam int SW    = DW + SHIFT + 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [CHW-1:0]  last_q, last_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            res_valid_q, res_valid_d;
    logic [CHW-1:0]  res_ch_q, res_ch_d;
    logic [DW-1:0]   res_avg_q, res_avg_d;
    logic [DW-1:0]   res_diff_q, res_diff_d;

    logic [DW-1:0]   sample;
    logic [SW-1:0]   sum_final;
    logic [SW-1:0]   avg_wide;
    logic [DW-1:0]   avg;
    logic [DW-1:0]   diff;
    logic            found;
    logic [CHW-1:0]  win;

    assign sample    = bus.ser_in[int'(ch_q)*DW +: DW];
    assign sum_final = sum_q + SW'(sample);

`ifdef AVG_ROUND_EN
    assign avg_wide = (sum_final + SW'(SAMPLES / 2)) >> SHIFT;
`else
    assign avg_wide = sum_final >> SHIFT;
`endif

    assign avg  = DW'(avg_wide);
    assign diff = (avg >= sample) ? (avg - sample) : (sample - avg);

    // Search begins just after the last served channel and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!found && bus.req[(int'(last_q) + i) % NCH]) begin
                found = 1'b1;
                win   = CHW'((int'(last_q) + i) % NCH);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_avg_d   = res_avg_q;
        res_diff_d  = res_diff_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NCH'(1) << win;
                    ch_d    = win;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                sum_d = sum_final;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(SAMPLES - 1)) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    res_avg_d   = avg;
                    res_diff_d  = diff;
                    grant_d     = '0;
                    last_d      = ch_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= CHW'(NCH - 1);
            ch_q        <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_avg_q   <= '0;
            res_diff_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_avg_q   <= res_avg_d;
            res_diff_q  <= res_diff_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sample_en = (state_q == ACC);
    assign bus.done      = (state_q == IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_avg   = res_avg_q;
    assign bus.res_diff  = res_diff_q;
endmodule

// File: tb/tb_avg_diff_scheduler.sv
// tb/tb_avg_diff_scheduler.sv - directed self-checking bench for avg_diff_scheduler
module tb_avg_diff_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    avg_diff_scheduler_if #(.NCH(4), .DW(8)) bus ();

    avg_diff_scheduler #(.NCH(4), .SAMPLES(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller leaves the DUT in IDLE with req set; returns in the result cycle.
    task automatic burst(input int ch, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic [7:0] exp_avg, input logic [7:0] exp_diff,
                         input logic [3:0] req_acc);
        logic [7:0]  s [4];
        logic [31:0] v;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        tick();
        bus.req = req_acc;
        check("grant", 32'(bus.grant), 32'(4'b0001 << ch));
        for (int k = 0; k < 4; k++) begin
            v = 32'hA5A5_A5A5;
            v[ch*8 +: 8] = s[k];
            bus.ser_in = v;
            check("acc_sample_en", 32'(bus.sample_en), 32'd1);
            check("acc_grant", 32'(bus.grant), 32'(4'b0001 << ch));
            check("acc_no_valid", 32'(bus.res_valid), 32'd0);
            check("acc_done", 32'(bus.done), 32'd0);
            tick();
        end
        bus.ser_in = 32'h5A5A_5A5A;
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_ch", 32'(bus.res_ch), 32'(ch));
        check("res_avg", 32'(bus.res_avg), 32'(exp_avg));
        check("res_diff", 32'(bus.res_diff), 32'(exp_diff));
        check("res_grant", 32'(bus.grant), 32'd0);
        check("res_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.req    = '0;
        bus.ser_in = '0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_sample_en", 32'(bus.sample_en), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_ch", 32'(bus.res_ch), 32'd0);
        check("rst_res_avg", 32'(bus.res_avg), 32'd0);
        check("rst_res_diff", 32'(bus.res_diff), 32'd0);
        check("rst_done", 32'(bus.done), 32'd1);
        rst = 1'b0;

        // Single request on ch2
        bus.req = 4'b0100;
        burst(2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 8'd15, 4'b0000);
        tick();
        check("single_idle_done", 32'(bus.done), 32'd1);
        check("single_idle_grant", 32'(bus.grant), 32'd0);
        check("single_valid_pulse", 32'(bus.res_valid), 32'd0);
        check("single_avg_hold", 32'(bus.res_avg), 32'd25);
        check("single_ch_hold", 32'(bus.res_ch), 32'd2);

        // Round robin from reset with all channels requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        burst(0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 4'b1111);
`ifdef AVG_ROUND_EN
        burst(1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd0, 4'b1111);
`else
        burst(1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 4'b1111);
`endif
        burst(2, 8'd0, 8'd0, 8'd0, 8'd100, 8'd25, 8'd75, 4'b1111);
        burst(3, 8'd7, 8'd9, 8'd11, 8'd13, 8'd10, 8'd3, 4'b1111);
        burst(0, 8'd200, 8'd200, 8'd200, 8'd0, 8'd150, 8'd150, 4'b1111);

        // Reset during the second ACC cycle of ch1
        bus.req = 4'b0011;
        tick();
        check("abort_grant", 32'(bus.grant), 32'b0010);
        tick();
        rst = 1'b1;
        tick();
        check("abort_grant_clear", 32'(bus.grant), 32'd0);
        check("abort_done", 32'(bus.done), 32'd1);
        check("abort_no_valid", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        burst(0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd10, 8'd6, 4'b0011);

        // ch3 drops its request right after grant
        bus.req = 4'b1000;
        burst(3, 8'd50, 8'd60, 8'd70, 8'd80, 8'd65, 8'd15, 4'b0000);
        tick();
        check("drop_no_regrant", 32'(bus.grant), 32'd0);
        check("drop_done", 32'(bus.done), 32'd1);
        tick();
        check("drop_still_idle", 32'(bus.sample_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_diff_scheduler.md
Name: avg_diff_scheduler

Overview:
- Time-shares one accumulate/average/abs-difference datapath among NCH serial sample sources.
- Round-robin arbitration picks one requesting channel and grants it for a burst of SAMPLES consecutive samples.
- At the end of the burst the block computes the burst average and |average − last sample|, then emits both tagged with the channel index.
- Sits between the per-channel sample front ends and the downstream result consumer.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- SAMPLES, 4, samples per burst; must be a power of 2 (2..16).
- DW, 8, sample and result width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NCH  per-channel request level; sampled only in IDLE.
- ser_in  input  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
- grant  output  NCH  one-hot registered grant; all zero when idle.
- sample_en  output  1  high on every cycle the granted channel's sample is consumed.
- res_valid  output  1  one-cycle pulse; result fields are valid.
- res_ch  output  clog2(NCH)  channel index of the result.
- res_avg  output  DW  burst average.
- res_diff  output  DW  |res_avg − final sample of the burst|.
- done  output  1  combinational; 1 when the state is IDLE.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; grant, sample_en, res_valid, res_ch, res_avg, res_diff all 0.
  - last-granted pointer = NCH-1, so ch0 has first priority.
- States: IDLE, ACC.
- IDLE at cycle t with any req bit high:
  - Search starts at channel (last+1) mod NCH and wraps; the first set bit wins, giving channel c.
  - Next state: grant<=onehot(c), cnt<=0, sum<=0, state<=ACC.
  - IDLE with no req: remain in IDLE; grant stays 0.
- ACC, cycles t+1 .. t+SAMPLES:
  - grant held; sample_en=1.
  - Each edge: sum <= sum + ser_in[c]; cnt increments.
  - sum width is DW+clog2(SAMPLES)+1; no overflow is possible.
- Final ACC cycle (cnt==SAMPLES-1):
  - avg = (sum + ser_in[c]) >> clog2(SAMPLES), truncated to DW bits.
  - diff = avg − ser_in[c] if avg ≥ ser_in[c], else ser_in[c] − avg.
  - Register res_avg, res_diff, res_ch=c; res_valid<=1; grant<=0; last<=c; state<=IDLE.
- res_valid is high for exactly the one cycle t+SAMPLES+1.
- res_ch, res_avg and res_diff hold their values until the next result overwrites them.
- Latency and throughput:
  - res_valid follows the arbitration cycle by SAMPLES+1 cycles.
  - The cycle in which res_valid is high is IDLE, so a new arbitration can occur in it.
  - Sustained throughput is one result per SAMPLES+1 cycles.
- req changes during ACC are ignored. A burst always completes once granted, even if its req drops.
- Reset asserted mid-burst aborts the burst:
  - no res_valid is produced; accumulated state is discarded.
  - the priority pointer returns to NCH-1.
- Channels with req held continuously are served in strict order c, c+1, ... mod NCH. No channel waits more than NCH-1 bursts.
- Equal avg and final sample give res_diff=0.

Optional Feature:
- Macro AVG_ROUND_EN.
- Defined: average rounds half up, avg = (sum_final + SAMPLES/2) >> clog2(SAMPLES). No overflow is possible because the sum width carries 1 extra bit.
- Undefined: the average is truncated, i.e. a plain shift.
- All other timing is identical in both builds.

Test Plan:
- Single request, ch2 (default parameters): req[2]=1 for one IDLE cycle; ch2 samples 10,20,30,40 → grant=4'b0100 for 4 cycles, sample_en=1 for 4 cycles, then res_valid=1 with res_ch=2, res_avg=25, res_diff=15; done=1 afterwards.
- Round-robin fairness: req=4'b1111 held from reset → grant order ch0,ch1,ch2,ch3,ch0; results spaced 5 cycles apart; exactly one res_valid per burst.
- Saturation: four samples of 255 → res_avg=255, res_diff=0; no wrap in sum (1020).
- Rounding: samples 1,1,2,2 (sum 6) → res_avg=1, res_diff=1 without AVG_ROUND_EN; res_avg=2, res_diff=0 with it.
- Reset mid-burst: rst=1 on the 2nd ACC cycle of ch1 → no res_valid; next cycle grant=0 and done=1; with req=4'b0011 the next grant goes to ch0.
- Request drop: req[3] deasserted after its grant → the burst still runs 4 cycles and res_valid pulses with res_ch=3; no re-grant to ch3 unless req[3] is high again in IDLE.
